// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - two-approach intersection controller with demand-driven green
// Pedestrian walk phase is built only when INTERSECTION_PED_EN is defined.
module intersection_ctrl #(
  parameter int unsigned T_GREEN_MIN  = 4,
  parameter int unsigned T_GREEN_MAX  = 12,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_ALL_RED    = 2,
  parameter int unsigned T_RED_YELLOW = 2,
  parameter int unsigned T_WALK       = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_ped_req,
  output logic       o_red_a,
  output logic       o_yellow_a,
  output logic       o_green_a,
  output logic       o_red_b,
  output logic       o_yellow_b,
  output logic       o_green_b,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic [2:0] o_phase
);

  typedef enum logic [2:0] {
    S_ALL_RED    = 3'd0,
    S_RED_YELLOW = 3'd1,
    S_GREEN      = 3'd2,
    S_YELLOW     = 3'd3,
    S_WALK       = 3'd4
  } state_t;

  localparam logic [7:0] C_GMIN = 8'(T_GREEN_MIN - 1);
  localparam logic [7:0] C_GMAX = 8'(T_GREEN_MAX - 1);
  localparam logic [7:0] C_YEL  = 8'(T_YELLOW - 1);
  localparam logic [7:0] C_AR   = 8'(T_ALL_RED - 1);
  localparam logic [7:0] C_RY   = 8'(T_RED_YELLOW - 1);
  localparam logic [7:0] C_WALK = 8'(T_WALK - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_dir;
  logic [7:0] r_cnt;
  logic       r_ped_pending;
  logic       r_from_walk;
  logic       r_ped_ack;
  logic       w_own_req;
  logic       w_demand;
  logic       w_ped_set;
  logic       w_enter_walk;
  logic       w_state_chg;

  assign w_own_req = r_dir ? i_req_b : i_req_a;

`ifdef INTERSECTION_PED_EN
  assign w_demand  = (r_dir ? i_req_a : i_req_b) | r_ped_pending;
  assign w_ped_set = i_ped_req && !r_ped_pending && !w_enter_walk;
`else
  logic w_unused_ped_req;
  assign w_unused_ped_req = i_ped_req;
  assign w_demand  = r_dir ? i_req_a : i_req_b;
  assign w_ped_set = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_ALL_RED;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ALL_RED:
        if (r_cnt == C_AR)
          w_state_nxt = (r_ped_pending && !r_from_walk) ? S_WALK : S_RED_YELLOW;
      S_RED_YELLOW:
        if (r_cnt == C_RY) w_state_nxt = S_GREEN;
      // Green with no competing demand is held indefinitely.
      S_GREEN:
        if (r_cnt >= C_GMIN && w_demand && (!w_own_req || r_cnt >= C_GMAX))
          w_state_nxt = S_YELLOW;
      S_YELLOW:
        if (r_cnt == C_YEL) w_state_nxt = S_ALL_RED;
      S_WALK:
        if (r_cnt == C_WALK) w_state_nxt = S_ALL_RED;
      default:
        w_state_nxt = S_ALL_RED;
    endcase
  end

  assign w_state_chg  = (w_state_nxt != r_state);
  assign w_enter_walk = (r_state == S_ALL_RED) && (w_state_nxt == S_WALK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dir         <= 1'b0;
      r_cnt         <= 8'd0;
      r_ped_pending <= 1'b0;
      r_from_walk   <= 1'b0;
      r_ped_ack     <= 1'b0;
    end else begin
      if (w_state_chg)
        r_cnt <= 8'd0;
      else if (!(r_state == S_GREEN && r_cnt >= C_GMAX))
        r_cnt <= r_cnt + 8'd1;

      if (r_state == S_YELLOW && w_state_chg)
        r_dir <= ~r_dir;

      if (r_state == S_WALK && w_state_chg)
        r_from_walk <= 1'b1;
      else if (r_state == S_ALL_RED && w_state_chg)
        r_from_walk <= 1'b0;

      // Walk entry clears the latch; a still-held request re-latches a cycle later.
      if (w_enter_walk)
        r_ped_pending <= 1'b0;
      else if (w_ped_set)
        r_ped_pending <= 1'b1;

      r_ped_ack <= w_ped_set;
    end
  end

  assign o_green_a  = !r_dir && (r_state == S_GREEN);
  assign o_yellow_a = !r_dir && (r_state == S_YELLOW || r_state == S_RED_YELLOW);
  assign o_red_a    = !(!r_dir && (r_state == S_GREEN || r_state == S_YELLOW));
  assign o_green_b  = r_dir && (r_state == S_GREEN);
  assign o_yellow_b = r_dir && (r_state == S_YELLOW || r_state == S_RED_YELLOW);
  assign o_red_b    = !(r_dir && (r_state == S_GREEN || r_state == S_YELLOW));
  assign o_walk     = (r_state == S_WALK);
  assign o_ped_ack  = r_ped_ack;
  assign o_phase    = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - directed bench for intersection_ctrl (honours INTERSECTION_PED_EN)
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       ped_req = 1'b0;
  logic       red_a, yellow_a, green_a, red_b, yellow_b, green_b, walk, ped_ack;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  // lamp vector order: red_a yellow_a green_a red_b yellow_b green_b walk
  localparam logic [6:0] AR  = 7'b1001000;
  localparam logic [6:0] RYA = 7'b1101000;
  localparam logic [6:0] GA  = 7'b0011000;
  localparam logic [6:0] YA  = 7'b0101000;
  localparam logic [6:0] RYB = 7'b1001100;
  localparam logic [6:0] GB  = 7'b1000010;
  localparam logic [6:0] WK  = 7'b1001001;

  wire [10:0] obs = {red_a, yellow_a, green_a, red_b, yellow_b, green_b, walk, phase, ped_ack};

  intersection_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_req_a(req_a), .i_req_b(req_b), .i_ped_req(ped_req),
    .o_red_a(red_a), .o_yellow_a(yellow_a), .o_green_a(green_a),
    .o_red_b(red_b), .o_yellow_b(yellow_b), .o_green_b(green_b),
    .o_walk(walk), .o_ped_ack(ped_ack), .o_phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] phase_of(input logic [6:0] v);
    case (v)
      AR:       return 3'd0;
      RYA, RYB: return 3'd1;
      GA, GB:   return 3'd2;
      YA:       return 3'd3;
      WK:       return 3'd4;
      default:  return 3'd7;
    endcase
  endfunction

  function automatic logic [6:0] idle_lamps(input int c);
    if (c < 2) return AR;
    if (c < 4) return RYA;
    return GA;
  endfunction

  function automatic logic [6:0] ped_lamps(input int c);
    if (c < 2)  return AR;
    if (c < 4)  return RYA;
    if (c < 8)  return GA;
    if (c < 11) return YA;
    if (c < 13) return AR;
    if (c < 19) return WK;
    if (c < 21) return AR;
    if (c < 23) return RYB;
    return GB;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; ped_req = 1'b1;
    repeat (2) @(posedge clk);
    exp = {AR, 3'd0, 1'b0};
    @(negedge clk);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    logic [6:0]  lamps;
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      lamps = idle_lamps(c);
      exp = {lamps, phase_of(lamps), 1'b0};
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_req_b();
    logic [6:0]  lamps;
    logic [10:0] exp;
    do_reset();
    req_b = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      if (c < 2)       lamps = AR;
      else if (c < 4)  lamps = RYA;
      else if (c < 8)  lamps = GA;
      else if (c < 11) lamps = YA;
      else if (c < 13) lamps = AR;
      else if (c < 15) lamps = RYB;
      else             lamps = GB;
      exp = {lamps, phase_of(lamps), 1'b0};
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL req_b cycle %0d: got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_green();
    logic [6:0]  lamps;
    logic [10:0] exp;
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      if (c < 2)       lamps = AR;
      else if (c < 4)  lamps = RYA;
      else if (c < 16) lamps = GA;
      else if (c < 19) lamps = YA;
      else if (c < 21) lamps = AR;
      else if (c < 23) lamps = RYB;
      else             lamps = GB;
      exp = {lamps, phase_of(lamps), 1'b0};
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL max_green cycle %0d: got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Requester raises PedReq at cycle 6 and drops it the cycle after it sees PedAck.
  task automatic test_ped(input bit with_reset);
    logic [6:0]  lamps;
    logic [10:0] exp;
    logic        ack_seen;
    int          last;
    ack_seen = 1'b0;
    last = with_reset ? 30 : 25;
    do_reset();
    for (int c = 0; c <= last; c++) begin
      if (c == 6) ped_req = 1'b1;
      if (ack_seen) ped_req = 1'b0;
      if (with_reset) rst = (c == 15);
      if (with_reset && c >= 16) lamps = idle_lamps(c - 16);
      else                       lamps = ped_lamps(c);
      exp = {lamps, phase_of(lamps), (c == 7)};
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ped%s cycle %0d: got %b want %b", with_reset ? "_reset" : "", c, obs, exp);
      end
      ack_seen = ack_seen | (ped_ack === 1'b1);
      @(posedge clk); #1;
    end
    ped_req = 1'b0;
  endtask

  task automatic test_ped_disabled();
    logic [6:0]  lamps;
    logic [10:0] exp;
    logic        ack_seen;
    ack_seen = 1'b0;
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      if (c == 6) ped_req = 1'b1;
      if (ack_seen) ped_req = 1'b0;
      lamps = idle_lamps(c);
      exp = {lamps, phase_of(lamps), 1'b0};
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ped_disabled cycle %0d: got %b want %b", c, obs, exp);
      end
      ack_seen = ack_seen | (ped_ack === 1'b1);
      @(posedge clk); #1;
    end
    ped_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_req_b();
    test_max_green();
`ifdef INTERSECTION_PED_EN
    test_ped(1'b0);
    test_ped(1'b1);
`else
    test_ped_disabled();
`endif
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
